// File: rtl/spectrum_power_reader.sv
// spectrum_power_reader
//   Reads the first half of an FFT result RAM (the positive-frequency bins)
//   one bin per cycle. For each bin it produces the power Re^2+Im^2 and an
//   8-bit log2 approximation of that power.
//
// Ports
//   Clock, Reset_n    : rising-edge clock, async active-low reset
//   Start             : one-cycle pulse that begins a pass (accepted in IDLE only)
//   RdRAMAddr         : RAM read address, natural or bit-reversed bin order
//   In_Re, In_Im      : RAM read data, valid ram_delay cycles after its address
//   Valid             : BinIdx/Power/Level carry a new bin this cycle
//   BinIdx            : natural-order bin index of the current output
//   Power             : Re^2+Im^2, full precision
//   Level             : 4*msb(Power) + the two bits below the msb
//   Busy              : pass in progress (READ or DRAIN)
//   End               : one-cycle pulse the cycle after the last Valid
module spectrum_power_reader #(
  parameter int bw_fftp   = 12,
  parameter int bw_data   = 18,
  parameter int ram_delay = 3,
  parameter int bitrev    = 0
) (
  input  logic                      Clock,
  input  logic                      Reset_n,
  input  logic                      Start,
  output logic [bw_fftp-1:0]        RdRAMAddr,
  input  logic signed [bw_data-1:0] In_Re,
  input  logic signed [bw_data-1:0] In_Im,
  output logic                      Valid,
  output logic [bw_fftp-2:0]        BinIdx,
  output logic [2*bw_data-1:0]      Power,
  output logic [7:0]                Level,
  output logic                      Busy,
  output logic                      End
);
  localparam int KW     = bw_fftp - 1;
  localparam int PW     = 2 * bw_data;
  // address register -> RAM data -> squares -> sum -> outputs
  localparam int STAGES = ram_delay + 3;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} stateT;

  stateT state, stateNext;
  logic [KW-1:0] kNext;

  // vldPipe[0]/kPipe[0] describe the address currently on RdRAMAddr;
  // index j is the same bin j cycles later.
  logic [STAGES:0]              vldPipe;
  logic [STAGES-1:0][KW-1:0]    kPipe;

  logic signed [PW-1:0] reExt, imExt;
  logic [PW-1:0]        reSq, imSq, sumQ;
  logic [PW+1:0]        sumExt;
  logic [7:0]           lvlNext;

  function automatic logic [bw_fftp-1:0] mapAddr(input logic [KW-1:0] k);
    logic [bw_fftp-1:0] a, r;
    a = {1'b0, k};
    r = a;
    if (bitrev != 0) begin
      for (int i = 0; i < bw_fftp; i++) r[i] = a[bw_fftp-1-i];
    end
    return r;
  endfunction

  always_comb begin
    stateNext = state;
    kNext     = kPipe[0];
    case (state)
      IDLE: if (Start) begin
        stateNext = READ;
        kNext     = '0;
      end
      READ: begin
        if (&kPipe[0]) stateNext = DRAIN;
        else           kNext     = kPipe[0] + KW'(1);
      end
      // leave once the oldest live bin is on the outputs and nothing follows it
      DRAIN: if (vldPipe[STAGES] && !(|vldPipe[STAGES-1:0])) stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign Busy  = (state == READ) || (state == DRAIN);
  assign End   = (state == DONE);
  assign Valid = vldPipe[STAGES];

  assign reExt  = {{bw_data{In_Re[bw_data-1]}}, In_Re};
  assign imExt  = {{bw_data{In_Im[bw_data-1]}}, In_Im};
  // two zero bits below the LSB make "bits under the leading one" safe at p<2
  assign sumExt = {sumQ, 2'b00};

  // Last match wins, so the loop settles on the leading one.
  always_comb begin
    lvlNext = '0;
    for (int i = 0; i < PW; i++) begin
      if (sumQ[i]) lvlNext = 8'(4 * i) + {6'd0, sumExt[i+1], sumExt[i]};
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      RdRAMAddr <= '0;
      vldPipe   <= '0;
      kPipe     <= '0;
      reSq      <= '0;
      imSq      <= '0;
      sumQ      <= '0;
      BinIdx    <= '0;
      Power     <= '0;
      Level     <= '0;
    end else begin
      state   <= stateNext;
      vldPipe <= {vldPipe[STAGES-1:0], stateNext == READ};
      kPipe   <= {kPipe[STAGES-2:0], kNext};
      if (stateNext == READ) RdRAMAddr <= mapAddr(kNext);
      // squares of two signed values are non-negative and fit in PW bits
      reSq <= reExt * reExt;
      imSq <= imExt * imExt;
      sumQ <= reSq + imSq;
      if (vldPipe[STAGES-1]) begin
        Power  <= sumQ;
        Level  <= lvlNext;
        BinIdx <= kPipe[STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_spectrum_power_reader.sv
// Bench for spectrum_power_reader: two instances (natural and bit-reversed
// addressing, bw_fftp=4, default data width) fed by a 3-cycle RAM model.
// A pass-relative cycle model predicts every output on every cycle.
module tb_spectrum_power_reader;
  localparam int FFTP = 4;
  localparam int DW   = 18;
  localparam int RD   = 3;

  logic Clock = 1'b0;
  logic Reset_n = 1'b0;
  logic Start = 1'b0;
  always #5 Clock = ~Clock;

  logic [FFTP-1:0]        addrA, addrB;
  logic signed [DW-1:0]   reA, imA, reB, imB;
  logic                   validA, validB, busyA, busyB, endA, endB;
  logic [FFTP-2:0]        binA, binB;
  logic [2*DW-1:0]        powA, powB;
  logic [7:0]             lvlA, lvlB;

  spectrum_power_reader #(.bw_fftp(FFTP), .bw_data(DW), .ram_delay(RD), .bitrev(0)) uA (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .RdRAMAddr(addrA),
    .In_Re(reA), .In_Im(imA), .Valid(validA), .BinIdx(binA), .Power(powA),
    .Level(lvlA), .Busy(busyA), .End(endA));

  spectrum_power_reader #(.bw_fftp(FFTP), .bw_data(DW), .ram_delay(RD), .bitrev(1)) uB (
    .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .RdRAMAddr(addrB),
    .In_Re(reB), .In_Im(imB), .Valid(validB), .BinIdx(binB), .Power(powB),
    .Level(lvlB), .Busy(busyB), .End(endB));

  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  int mode = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  // ---- RAM content per mode ----
  function automatic int dRe(input int ad, input int m);
    case (m)
      0: return ad;
      1: return -131072;
      default: return 3 * ad - 20;
    endcase
  endfunction
  function automatic int dIm(input int ad, input int m);
    case (m)
      0: return 0;
      1: return -131072;
      default: return 7 - ad * ad;
    endcase
  endfunction

  logic [FFTP-1:0] aqA [RD];
  logic [FFTP-1:0] aqB [RD];
  always @(posedge Clock) begin
    aqA[0] <= addrA;
    aqB[0] <= addrB;
    for (int i = 1; i < RD; i++) begin
      aqA[i] <= aqA[i-1];
      aqB[i] <= aqB[i-1];
    end
  end
  always_comb begin
    reA = DW'(dRe(int'(aqA[RD-1]), mode));
    imA = DW'(dIm(int'(aqA[RD-1]), mode));
    reB = DW'(dRe(int'(aqB[RD-1]), mode));
    imB = DW'(dIm(int'(aqB[RD-1]), mode));
  end

  // ---- model ----
  function automatic int mapAd(input int inst, input int k);
    if (inst == 0) return k;
    return ((k & 1) << 3) | ((k & 2) << 1) | ((k & 4) >> 1) | ((k & 8) >> 3);
  endfunction
  function automatic longint pwOf(input int ad, input int m);
    longint re, im;
    re = longint'(dRe(ad, m));
    im = longint'(dIm(ad, m));
    return re * re + im * im;
  endfunction
  function automatic int lvlOf(input longint p);
    int e;
    longint v;
    if (p == 0) return 0;
    e = 0;
    v = p;
    while (v > 1) begin
      v = v >> 1;
      e++;
    end
    if (e == 0) return 0;
    if (e == 1) return 4 + 2 * int'(p & 1);
    return 4 * e + int'((p >> (e - 2)) & 3);
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s cyc=%0d: got %0d expected %0d", nm, cyc, act, exp);
  endtask

  bit     pAct = 0;
  int     pS = 0;
  int     pMode = 0;
  int     endCnt = 0;
  bit     eV, eB, eE;
  longint hAddr [2];
  longint hBin [2];
  longint hPow [2];
  longint hLvl [2];
  int     sqTab [8] = '{0, 1, 4, 9, 16, 25, 36, 49};
  int     brTab [8] = '{0, 8, 4, 12, 2, 10, 6, 14};

  task automatic chkInst(input int i, input longint v, input longint b, input longint e,
                         input longint ad, input longint bn, input longint pw, input longint lv);
    string t;
    t = (i == 0) ? "A" : "B";
    chk({t, ".Valid"}, v, longint'(eV));
    chk({t, ".Busy"}, b, longint'(eB));
    chk({t, ".End"}, e, longint'(eE));
    chk({t, ".RdRAMAddr"}, ad, hAddr[i]);
    chk({t, ".BinIdx"}, bn, hBin[i]);
    chk({t, ".Power"}, pw, hPow[i]);
    chk({t, ".Level"}, lv, hLvl[i]);
  endtask

  always @(negedge Clock) begin
    int a;
    if (!Reset_n) begin
      pAct = 0;
      eV = 0; eB = 0; eE = 0;
      for (int i = 0; i < 2; i++) begin
        hAddr[i] = 0; hBin[i] = 0; hPow[i] = 0; hLvl[i] = 0;
      end
    end else begin
      a = pAct ? cyc - pS : -1;
      eB = (a >= 1 && a <= 14);
      eE = (a == 15);
      eV = (a >= 7 && a <= 14);
      for (int i = 0; i < 2; i++) begin
        if (a >= 1 && a <= 8) hAddr[i] = longint'(mapAd(i, a - 1));
        if (eV) begin
          hBin[i] = longint'(a - 7);
          hPow[i] = pwOf(mapAd(i, a - 7), pMode);
          hLvl[i] = longint'(lvlOf(hPow[i]));
        end
      end
      if (pAct && endA) endCnt++;
      // hand-computed anchors
      if (a >= 1 && a <= 8) chk("B.addr_bitrev_seq", longint'(addrB), longint'(brTab[a-1]));
      if (pMode == 0 && eV) chk("A.power_square_seq", longint'(powA), longint'(sqTab[a-7]));
      if (pMode == 0 && a == 15) chk("A.end_at_15", longint'(endA), 1);
      if (pMode == 1 && eV) begin
        chk("A.power_max", longint'(powA), 64'd34359738368);
        chk("A.level_max", longint'(lvlA), 140);
      end
      if (a >= 16) begin
        chk("end_pulses_per_pass", longint'(endCnt), 1);
        pAct = 0;
      end
    end
    chkInst(0, longint'(validA), longint'(busyA), longint'(endA), longint'(addrA),
            longint'(binA), longint'(powA), longint'(lvlA));
    chkInst(1, longint'(validB), longint'(busyB), longint'(endB), longint'(addrB),
            longint'(binB), longint'(powB), longint'(lvlB));
    // Start seen now is sampled at the next edge; only an idle block takes it
    if (Reset_n && Start && !pAct) begin
      pAct = 1;
      pS = cyc;
      pMode = mode;
      endCnt = 0;
    end
  end

  task automatic pulseStart();
    @(posedge Clock); #1 Start = 1'b1;
    @(posedge Clock); #1 Start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  initial begin
    longint pinP [6] = '{0, 1, 6, 7, 2, 3};
    int     pinL [6] = '{0, 0, 10, 11, 4, 6};
    for (int i = 0; i < 6; i++) chk("level_model_pin", longint'(lvlOf(pinP[i])), longint'(pinL[i]));

    idle(2);
    Reset_n = 1'b1;
    idle(3);

    mode = 0;            // Re=addr, Im=0
    pulseStart();
    idle(20);

    mode = 2;            // mixed signs; second Start lands in READ
    pulseStart();
    idle(1);
    pulseStart();
    idle(20);

    mode = 1;            // most negative Re and Im
    pulseStart();
    idle(20);

    mode = 0;            // abort during DRAIN
    pulseStart();
    idle(10);
    Reset_n = 1'b0;
    #1;
    chk("A.Valid_in_reset", longint'(validA), 0);
    chk("A.Power_in_reset", longint'(powA), 0);
    chk("A.RdRAMAddr_in_reset", longint'(addrA), 0);
    idle(1);
    Reset_n = 1'b1;
    idle(20);

    pulseStart();        // full pass after the abort
    idle(20);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule

// File: doc/spectrum_power_reader.md
SPECTRUM_POWER_READER -- requirements
Module: spectrum_power_reader

Interface
REQ-001 SHALL have parameter bw_fftp, default 12, meaning log2 of FFT points; bins read = 2^(bw_fftp-1).
REQ-002 SHALL have parameter bw_data, default 18, meaning signed width of each Re/Im sample.
REQ-003 SHALL have parameter ram_delay, default 3, meaning RAM address-to-data latency in cycles.
REQ-004 SHALL have parameter bitrev, default 0, meaning 1 = RAM address is the bit-reversed bin index.
REQ-005 SHALL have port Clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 SHALL have port Reset_n, input, 1, meaning asynchronous, active-low reset.
REQ-007 SHALL have port Start, input, 1, meaning one-cycle pulse that begins a read pass; driven by the FFT core End.
REQ-008 SHALL have port RdRAMAddr, output, bw_fftp, meaning the result RAM read address.
REQ-009 SHALL have ports In_Re and In_Im, input, bw_data signed each, meaning RAM read data valid ram_delay cycles after its address.
REQ-010 SHALL have port Valid, output, 1, meaning BinIdx/Power/Level are valid this cycle.
REQ-011 SHALL have port BinIdx, output, bw_fftp-1, meaning the natural-order bin index of the current output.
REQ-012 SHALL have port Power, output, 2*bw_data unsigned, meaning Re^2+Im^2.
REQ-013 SHALL have port Level, output, 8, meaning the log2 approximation of Power.
REQ-014 SHALL have ports Busy and End, output, 1 each, meaning pass in progress and a one-cycle pass-complete pulse.

Function
REQ-015 SHALL implement a state machine with states IDLE, READ, DRAIN and DONE.
REQ-016 SHALL move IDLE->READ on Start; Start SHALL be ignored in every state other than IDLE.
REQ-017 SHALL, in READ, issue bin counter k = 0..2^(bw_fftp-1)-1, one per cycle; the first address (k=0) SHALL appear the cycle after Start.
REQ-018 SHALL drive RdRAMAddr = {0,k} when bitrev=0, and the bw_fftp-bit reversal of {0,k} when bitrev=1.
REQ-019 SHALL move READ->DRAIN after the last k is issued, and stay in DRAIN until the last Valid has been output.
REQ-020 SHALL move DRAIN->DONE; DONE SHALL assert End for exactly one cycle (the cycle after the last Valid) and then return to IDLE.
REQ-021 SHALL hold RdRAMAddr at its last value outside READ.
REQ-022 SHALL assert Busy from the first READ cycle through the last DRAIN cycle; Busy SHALL be 0 while End=1.
REQ-023 SHALL register In_Re and In_Im squares in pipe stage 1, register their sum in stage 2, and register Level in stage 3.
REQ-024 SHALL make total latency from an address to its Valid output ram_delay+3 cycles.
REQ-025 SHALL carry k through a matching delay line to BinIdx.
REQ-026 SHALL keep Valid, BinIdx, Power and Level mutually aligned.
REQ-027 SHALL assert Valid on exactly 2^(bw_fftp-1) consecutive cycles per pass.
REQ-028 SHALL compute Power with full precision and no saturation; (-2^(bw_data-1))^2 * 2 = 2^(2*bw_data-1) fits.
REQ-029 SHALL compute Level as follows, with p = the index of the leading one of Power:
  - Level = 4*p + {Power[p-1], Power[p-2]}; a bit below index 0 reads as 0.
  - Level = 0 when Power = 0.
  - Maximum Level = 4*35 = 140 at the default widths.
REQ-030 SHALL hold Power, Level and BinIdx at their last values when Valid = 0.

Reset
REQ-031 SHALL, while Reset_n = 0, asynchronously force:
  - state to IDLE;
  - RdRAMAddr, BinIdx, Power and Level to 0;
  - Valid, Busy and End to 0;
  - all pipeline valid bits to 0.
REQ-032 SHALL treat Reset_n low mid-pass as an abort: no further Valid or End is produced after release, and the block accepts the next Start normally.

Verification
REQ-033 SHALL be verified with bw_fftp=4, ram_delay=3 and a RAM model returning Re=addr, Im=0 on Start at cycle 0 -> RdRAMAddr 0..7 on cycles 1..8; Valid on cycles 7..14 with Power = 0,1,4,...,49; End on cycle 15 only.
REQ-034 SHALL be verified with bitrev=1 and bw_fftp=4 -> RdRAMAddr sequence 0,8,4,12,2,10,6,14 while BinIdx = 0..7.
REQ-035 SHALL be verified with In_Re = In_Im = -131072 at the default widths -> Power = 2^35 and Level = 140.
REQ-036 SHALL be verified with Power values 0, 1, 6 and 7 -> Level 0, 0, 10 and 11.
REQ-037 SHALL be verified with a second Start pulse during READ -> ignored, exactly one End per pass.
REQ-038 SHALL be verified with Reset_n pulsed low during DRAIN -> all outputs 0 immediately, no End; a subsequent Start produces a complete pass.
